// File: rtl/spi_mem_loader_pkg.sv
// Shared types and constants for the SPI program loader: FSM states,
// command opcodes and frame geometry.
package spi_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    COMMIT = 3'd4,
    SKIP   = 3'd5
  } state_t;

  localparam logic [7:0] CMD_RUN    = 8'h01;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam int         FRAME_BITS = 48;

  function automatic logic is_known_cmd(input logic [7:0] cmd);
    logic known;
    case (cmd)
      CMD_RUN, CMD_WRITE, CMD_READ: known = 1'b1;
      default:                      known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/spi_mem_loader_if.sv
// Bundles the SPI pins and the RAM-side port of the loader; the loader
// itself uses the slave view, the host/RAM environment the master view.
interface spi_mem_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  sclk;
  logic                  cs_n;
  logic                  mosi;
  logic                  miso;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_owner;
  logic                  cpu_hold;

  modport slave (
    input  sclk, cs_n, mosi, mem_rdata,
    output miso, mem_addr, mem_wdata, mem_we, mem_owner, cpu_hold
  );

  modport master (
    output sclk, cs_n, mosi, mem_rdata,
    input  miso, mem_addr, mem_wdata, mem_we, mem_owner, cpu_hold
  );
endinterface

// File: rtl/spi_mem_loader_sync.sv
// Brings the asynchronous SPI pins into the clock domain and derives
// single-cycle sclk rise/fall and cs_n fall strobes.
module spi_sync (
  input  logic clock,
  input  logic reset,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n_sync,
  output logic cs_n_fall,
  output logic mosi_sync
);

  logic sclk_meta_r, sclk_sync_r, sclk_prev_r;
  logic cs_meta_r, cs_sync_r, cs_prev_r;
  logic mosi_meta_r, mosi_sync_r;

  // Two-stage synchronizers plus one history stage for edge detection
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_prev_r <= 1'b0;
      cs_meta_r   <= 1'b1;
      cs_sync_r   <= 1'b1;
      cs_prev_r   <= 1'b1;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
    end else begin
      sclk_meta_r <= sclk;
      sclk_sync_r <= sclk_meta_r;
      sclk_prev_r <= sclk_sync_r;
      cs_meta_r   <= cs_n;
      cs_sync_r   <= cs_meta_r;
      cs_prev_r   <= cs_sync_r;
      mosi_meta_r <= mosi;
      mosi_sync_r <= mosi_meta_r;
    end
  end

  assign sclk_rise = sclk_sync_r & ~sclk_prev_r;
  assign sclk_fall = ~sclk_sync_r & sclk_prev_r;
  assign cs_n_sync = cs_sync_r;
  assign cs_n_fall = ~cs_sync_r & cs_prev_r;
  assign mosi_sync = mosi_sync_r;

endmodule

// File: rtl/spi_mem_loader.sv
// SPI-slave program loader: decodes 48-bit CMD/ADDR/DATA frames into RAM
// writes and read-backs, and releases the CPU on a RUN command.
module spi_mem_loader
  import spi_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input logic              clock,
  input logic              reset,
  spi_mem_loader_if.slave  bus
);

  localparam logic [5:0] CMD_LAST_C  = 6'd7;
  localparam logic [5:0] ADDR_LAST_C = 6'(8 + ADDR_WIDTH - 1);
  localparam logic [5:0] DATA_LAST_C = 6'(FRAME_BITS - 1);

  logic sclk_rise_s, sclk_fall_s, cs_n_s, cs_fall_s, mosi_s;

  state_t                state_r, state_nxt_s;
  logic [5:0]            bit_cnt_r;
  logic [7:0]            cmd_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic [DATA_WIDTH-1:0] tx_r;
  logic                  rd_pend_r, rd_load_r;

  logic                  miso_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [DATA_WIDTH-1:0] mem_wdata_r;
  logic                  mem_we_r;
  logic                  mem_owner_r;
  logic                  cpu_hold_r;

  logic [7:0]            cmd_shift_s;
  logic [ADDR_WIDTH-1:0] addr_shift_s;
  logic [DATA_WIDTH-1:0] data_shift_s;
  logic                  last_bit_s;
  logic                  we_set_s, run_set_s, rd_issue_s, miso_en_s;

  spi_sync u_sync (
    .clock     (clock),
    .reset     (reset),
    .sclk      (bus.sclk),
    .cs_n      (bus.cs_n),
    .mosi      (bus.mosi),
    .sclk_rise (sclk_rise_s),
    .sclk_fall (sclk_fall_s),
    .cs_n_sync (cs_n_s),
    .cs_n_fall (cs_fall_s),
    .mosi_sync (mosi_s)
  );

  assign cmd_shift_s  = {cmd_r[6:0], mosi_s};
  assign addr_shift_s = {addr_r[ADDR_WIDTH-2:0], mosi_s};
  assign data_shift_s = {data_r[DATA_WIDTH-2:0], mosi_s};
  // A final rising edge outranks a simultaneous cs_n release so the frame still commits
  assign last_bit_s   = (state_r == DATA) && sclk_rise_s && (bit_cnt_r == DATA_LAST_C);

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cs_fall_s) state_nxt_s = CMD;
        else           state_nxt_s = IDLE;
      end
      CMD: begin
        if (cs_n_s)
          state_nxt_s = IDLE;
        else if (sclk_rise_s && (bit_cnt_r == CMD_LAST_C))
          state_nxt_s = is_known_cmd(cmd_shift_s) ? ADDR : SKIP;
        else
          state_nxt_s = CMD;
      end
      ADDR: begin
        if (cs_n_s)                                          state_nxt_s = IDLE;
        else if (sclk_rise_s && (bit_cnt_r == ADDR_LAST_C))  state_nxt_s = DATA;
        else                                                 state_nxt_s = ADDR;
      end
      DATA: begin
        if (last_bit_s)  state_nxt_s = COMMIT;
        else if (cs_n_s) state_nxt_s = IDLE;
        else             state_nxt_s = DATA;
      end
      COMMIT:  state_nxt_s = IDLE;
      SKIP: begin
        if (cs_n_s) state_nxt_s = IDLE;
        else        state_nxt_s = SKIP;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode; after RUN every memory action is suppressed
  always_comb begin
    we_set_s   = last_bit_s && (cmd_r == CMD_WRITE) && mem_owner_r;
    run_set_s  = last_bit_s && (cmd_r == CMD_RUN) && mem_owner_r;
    rd_issue_s = (state_r == ADDR) && sclk_rise_s && !cs_n_s &&
                 (bit_cnt_r == ADDR_LAST_C) && (cmd_r == CMD_READ) && mem_owner_r;
    miso_en_s  = (state_r == DATA) && !cs_n_s && (cmd_r == CMD_READ) && mem_owner_r;
  end

  // Frame receive shift registers and bit counter, cleared between frames
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bit_cnt_r <= 6'd0;
      cmd_r     <= 8'h00;
      addr_r    <= '0;
      data_r    <= '0;
    end else if (state_r == IDLE) begin
      bit_cnt_r <= 6'd0;
      cmd_r     <= 8'h00;
      addr_r    <= '0;
      data_r    <= '0;
    end else if (sclk_rise_s) begin
      case (state_r)
        CMD: begin
          cmd_r     <= cmd_shift_s;
          bit_cnt_r <= bit_cnt_r + 6'd1;
        end
        ADDR: begin
          addr_r    <= addr_shift_s;
          bit_cnt_r <= bit_cnt_r + 6'd1;
        end
        DATA: begin
          data_r    <= data_shift_s;
          bit_cnt_r <= bit_cnt_r + 6'd1;
        end
        default: begin
          bit_cnt_r <= bit_cnt_r;
        end
      endcase
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // RAM port and CPU control registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      mem_we_r    <= 1'b0;
      mem_owner_r <= 1'b1;
      cpu_hold_r  <= 1'b1;
    end else begin
      mem_we_r <= we_set_s;
      if (we_set_s) begin
        mem_addr_r  <= addr_r;
        mem_wdata_r <= data_shift_s;
      end else if (rd_issue_s) begin
        mem_addr_r  <= addr_shift_s;
      end else begin
        mem_addr_r  <= mem_addr_r;
      end
      if (run_set_s) begin
        mem_owner_r <= 1'b0;
        cpu_hold_r  <= 1'b0;
      end else begin
        mem_owner_r <= mem_owner_r;
        cpu_hold_r  <= cpu_hold_r;
      end
    end
  end

  // Read-back: wait for the RAM latency, load the word, then shift it out on sclk falls
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_pend_r <= 1'b0;
      rd_load_r <= 1'b0;
      tx_r      <= '0;
      miso_r    <= 1'b0;
    end else begin
      rd_pend_r <= rd_issue_s;
      rd_load_r <= rd_pend_r;
      if (rd_load_r)
        tx_r <= bus.mem_rdata;
      else if (miso_en_s && sclk_fall_s)
        tx_r <= {tx_r[DATA_WIDTH-2:0], 1'b0};
      else if (state_r == IDLE)
        tx_r <= '0;
      else
        tx_r <= tx_r;
      if (!miso_en_s)
        miso_r <= 1'b0;
      else if (sclk_fall_s)
        miso_r <= tx_r[DATA_WIDTH-1];
      else
        miso_r <= miso_r;
    end
  end

  assign bus.miso      = miso_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_owner = mem_owner_r;
  assign bus.cpu_hold  = cpu_hold_r;

endmodule

// File: doc/spi_mem_loader.md
# spi_mem_loader

SPI-slave program loader sitting upstream of the CPU's single-port program/data RAM (8-bit address, 32-bit data). An external host streams framed commands over SPI (mode 0, MSB first) to write or read back RAM words and finally release the CPU. While loading, the block owns the RAM port and holds the CPU stopped; after the release command it stops driving the RAM and deasserts `cpu_hold`.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, RAM address width
- `DATA_WIDTH`, 32, RAM word width

Ports:
- `clock`  in  1  system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `sclk`  in  1  SPI clock from host, asynchronous to `clock`
- `cs_n`  in  1  SPI chip select, active-low
- `mosi`  in  1  SPI data in
- `miso`  out  1  SPI data out
- `mem_addr`  out  ADDR_WIDTH  RAM address
- `mem_wdata`  out  DATA_WIDTH  RAM write data
- `mem_we`  out  1  RAM write enable, one-cycle pulse
- `mem_rdata`  in  DATA_WIDTH  RAM read data, valid one clock after `mem_addr`
- `mem_owner`  out  1  1 = loader drives RAM port, 0 = CPU drives it (external mux select)
- `cpu_hold`  out  1  1 = CPU held in reset

## Operation
- Frame = 48 bits while `cs_n` low: CMD[7:0], ADDR[7:0], DATA[31:0]; MSB first; mosi sampled on sclk rising, miso changed on sclk falling.
- Commands: 0x02 WRITE (store DATA at ADDR), 0x03 READ (shift out RAM[ADDR] during DATA phase, DATA bits ignored), 0x01 RUN (set `cpu_hold`=0, `mem_owner`=0; ADDR/DATA ignored). Any other CMD: rest of frame ignored, no RAM access, miso=0.
- `sclk`, `cs_n`, `mosi` pass through 2-FF synchronizers; edges detected on synchronized `sclk`. Requires `clock` ≥ 8× sclk frequency.
- FSM states: IDLE → CMD (cs_n falls) → ADDR (8 bits) → DATA (32 bits) → COMMIT → IDLE. From CMD with unknown opcode → SKIP until cs_n high. cs_n rising in any state → IDLE, no RAM write, shift registers cleared.
- Bit counter 6 bits, counts sampled rising edges in frame; bits after the 48th ignored (no second write).
- READ: on 16th rising edge, drive `mem_addr`=ADDR; next cycle load `mem_rdata` into 32-bit tx shift register; bit 31 presented on first falling edge after, one bit per falling edge.
- After RUN, later WRITE/READ frames are decoded but ignored (no `mem_we`, miso=0); only reset re-enters loading mode.
- miso = 0 whenever cs_n high or not in READ DATA phase.

## Timing
- Reset values: `miso`=0, `mem_addr`=0, `mem_wdata`=0, `mem_we`=0, `mem_owner`=1, `cpu_hold`=1; FSM IDLE, counters 0.
- Input latency: sclk edge visible internally 3 clocks after pin edge (2 sync + edge reg).
- WRITE: `mem_we` high for exactly one clock in COMMIT, first cycle after 48th rising edge detected; `mem_addr`/`mem_wdata` stable that cycle and held afterwards.
- RUN: `cpu_hold` and `mem_owner` fall together in COMMIT cycle of a completed RUN frame, stay 0 until reset.
- cs_n high with no intervening rising edge after 48th bit still commits (commit precedes cs_n detection due to latency ordering: edge processed first).
- Reset asserted mid-frame: all outputs to reset values immediately; partial frame discarded.

## Structure
- Package `spi_loader_pkg`: FSM state enum (IDLE, CMD, ADDR, DATA, COMMIT, SKIP), command constants CMD_RUN=8'h01, CMD_WRITE=8'h02, CMD_READ=8'h03, FRAME_BITS=48.
- Sub-module `spi_sync`: 2-FF synchronizer plus rise/fall edge detect for sclk, synchronized cs_n and mosi outputs.
- External 2:1 mux on RAM port selected by `mem_owner` lives in the CPU top, not in this block.

## Test plan
- After reset release: `cpu_hold`=1, `mem_owner`=1, `mem_we`=0, miso=0.
- WRITE frame 0x02,0x05,0xDEADBEEF -> single `mem_we` pulse with `mem_addr`=0x05, `mem_wdata`=0xDEADBEEF; RAM[5] reads back 0xDEADBEEF.
- READ frame 0x03,0x05 after above -> miso shifts 0xDEADBEEF MSB first across DATA phase; no `mem_we`.
- WRITE frame aborted by cs_n high after 30 bits -> no `mem_we`; next full WRITE 0x02,0x06,0x00000007 writes RAM[6]=7 correctly.
- Unknown CMD 0xAA full frame -> no RAM access, miso=0, following WRITE frame works.
- RUN frame 0x01 -> `cpu_hold`,`mem_owner` fall in same cycle; subsequent WRITE 0x02,0x00,0x12345678 produces no `mem_we`.
